// File: rtl/run_ctrl_pkg.sv
// run_ctrl shared types and defaults.
// State encoding and parameter defaults for the run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } run_state_t;

  localparam int HALT_PC_DEF = 128;
  localparam int CLR_CYC_DEF = 2;
  localparam int TIMEOUT_DEF = 4000;
  localparam int CLW         = 4;

endpackage

// File: rtl/run_ctrl_if.sv
// run_ctrl host/core bundle.
// Host drives req and the core PC; controller drives the rest.
interface run_ctrl_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          req;
  logic [D-1:0]  prog_ctr;
  logic          core_rst;
  logic          core_en;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_cnt;

  modport master (
    output req, prog_ctr,
    input  core_rst, core_en, busy,
    input  done, timeout, cycle_cnt
  );

  modport slave (
    input  req, prog_ctr,
    output core_rst, core_en, busy,
    output done, timeout, cycle_cnt
  );
endinterface

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter for RUN cycles.
// Clear beats increment; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q;

  // count register: clear, else bump unless saturated
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/run_ctrl.sv
// Run controller: reset, launch and stop the core.
// IDLE -> CLEAR -> RUN -> DONE with req handshake.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int D       = 12,
  parameter int HALT_PC = HALT_PC_DEF,
  parameter int CLR_CYC = CLR_CYC_DEF,
  parameter int CW      = 16,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic       clk,
  input logic       reset,
  run_ctrl_if.slave bus
);
  localparam logic [CLW-1:0] CLR_LOAD = CLW'(CLR_CYC - 1);
  localparam logic [CW-1:0]  LIM_M1   = CW'(TIMEOUT - 1);
  localparam logic [D-1:0]   HALT_V   = D'(HALT_PC);

  run_state_t     state_q, state_d;
  logic           armed_q, armed_d;
  logic [CLW-1:0] clr_q, clr_d;
  logic           to_q, to_d;
  logic           cnt_clr, cnt_inc;
  logic [CW-1:0]  cnt;
  logic           halt, at_lim;

  sat_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt)
  );

  assign halt   = (bus.prog_ctr == HALT_V);
  assign at_lim = (cnt == LIM_M1);

  // state, arm flag, clear counter, timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      clr_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      clr_q   <= clr_d;
      to_q    <= to_d;
    end
  end

  // next state; abort beats halt beats limit
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    clr_d   = clr_q;
    to_d    = to_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.req) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = CLEAR;
          armed_d = 1'b0;
          cnt_clr = 1'b1;
          to_d    = 1'b0;
          clr_d   = CLR_LOAD;
        end
      end
      CLEAR: begin
        if (!bus.req) begin
          state_d = IDLE;
        end else if (clr_q == '0) begin
          state_d = RUN;
        end else begin
          clr_d = clr_q - 1'b1;
        end
      end
      RUN: begin
        cnt_inc = 1'b1;
        if (!bus.req) begin
          state_d = IDLE;
        end else if (halt) begin
          state_d = DONE;
        end else if (at_lim) begin
          state_d = DONE;
          to_d    = 1'b1;
        end
      end
      DONE: begin
        if (!bus.req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from registered state
  always_comb begin
    bus.core_rst = 1'b0;
    bus.core_en  = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    unique case (state_q)
      IDLE:  bus.core_rst = 1'b1;
      CLEAR: begin
        bus.core_rst = 1'b1;
        bus.busy     = 1'b1;
      end
      RUN: begin
        bus.core_en = 1'b1;
        bus.busy    = 1'b1;
      end
      DONE:  bus.done = 1'b1;
      default: bus.core_rst = 1'b1;
    endcase
  end

  assign bus.timeout   = to_q;
  assign bus.cycle_cnt = cnt;
endmodule

// File: tb/tb_run_ctrl.sv
// run_ctrl bench: directed cases then random req/pc/reset.
// Outputs checked each negedge against a phase model.
module tb_run_ctrl;
  localparam int PH_IDLE  = 0;
  localparam int PH_CLEAR = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_DONE  = 3;
  localparam int CLRN     = 2;
  localparam int HALT     = 128;
  localparam int LIM      = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  int m_ph    = PH_IDLE;
  bit m_armed = 1'b0;
  int m_left  = 0;
  int m_cnt   = 0;
  bit m_to    = 1'b0;

  int nclr;
  int ndone;

  run_ctrl_if #(.D(12), .CW(16)) bus ();

  run_ctrl #(
    .D       (12),
    .HALT_PC (HALT),
    .CLR_CYC (CLRN),
    .CW      (16),
    .TIMEOUT (LIM)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] rnd_pc();
    logic [11:0] v;
    v = 12'($urandom_range(0, 4095));
    if (v == 12'd128) v = 12'd0;
    return v;
  endfunction

  // reference: what one rising edge does to the run
  always @(posedge clk) begin
    if (rst) begin
      m_ph    = PH_IDLE;
      m_armed = 1'b0;
      m_cnt   = 0;
      m_to    = 1'b0;
      m_left  = 0;
    end else begin
      case (m_ph)
        PH_IDLE: begin
          if (!bus.req) m_armed = 1'b1;
          else if (m_armed) begin
            m_ph    = PH_CLEAR;
            m_armed = 1'b0;
            m_cnt   = 0;
            m_to    = 1'b0;
            m_left  = CLRN;
          end
        end
        PH_CLEAR: begin
          if (!bus.req) m_ph = PH_IDLE;
          else begin
            m_left = m_left - 1;
            if (m_left == 0) m_ph = PH_RUN;
          end
        end
        PH_RUN: begin
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          if (!bus.req) m_ph = PH_IDLE;
          else if (int'(bus.prog_ctr) == HALT) m_ph = PH_DONE;
          else if (m_cnt == LIM) begin
            m_ph = PH_DONE;
            m_to = 1'b1;
          end
        end
        default: if (!bus.req) m_ph = PH_IDLE;
      endcase
    end
  end

  // compare every cycle away from the active edge
  always @(negedge clk) begin
    chk("core_rst", bus.core_rst,
        (m_ph == PH_IDLE) || (m_ph == PH_CLEAR));
    chk("core_en", bus.core_en, m_ph == PH_RUN);
    chk("busy", bus.busy,
        (m_ph == PH_CLEAR) || (m_ph == PH_RUN));
    chk("done", bus.done, m_ph == PH_DONE);
    chk("timeout", bus.timeout, m_to);
    chk("cycle_cnt", bus.cycle_cnt, m_cnt);
  end

  task automatic cyc(input logic r, input logic q,
                     input logic [11:0] pc);
    rst          = r;
    bus.req      = q;
    bus.prog_ctr = pc;
    @(negedge clk);
  endtask

  initial begin
    logic q;
    logic r;
    logic [11:0] pc;
    bus.req      = 1'b0;
    bus.prog_ctr = '0;

    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("rst_core_rst", bus.core_rst, 1);
    chk("rst_core_en", bus.core_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.cycle_cnt, 0);
    cyc(0, 0, 0);

    // halt after 50 RUN cycles
    nclr = 0;
    for (int i = 0; i < 300 && !bus.done; i++) begin
      cyc(0, 1, (m_ph == PH_RUN && m_cnt == 49)
                ? 12'd128 : rnd_pc());
      if (bus.core_rst && bus.busy) nclr++;
    end
    chk("halt_done", bus.done, 1);
    chk("halt_to", bus.timeout, 0);
    chk("halt_cnt", bus.cycle_cnt, 50);
    chk("clear_len", nclr, 2);
    cyc(0, 0, 0);
    chk("keep_cnt", bus.cycle_cnt, 50);
    cyc(0, 0, 0);

    // pc never at halt: limit stop
    for (int i = 0; i < 400 && !bus.done; i++)
      cyc(0, 1, rnd_pc());
    chk("lim_done", bus.done, 1);
    chk("lim_to", bus.timeout, 1);
    chk("lim_cnt", bus.cycle_cnt, 200);
    cyc(0, 0, 0);
    chk("keep_to", bus.timeout, 1);
    cyc(0, 0, 0);

    // halt on the limit edge
    for (int i = 0; i < 400 && !bus.done; i++)
      cyc(0, 1, (m_ph == PH_RUN && m_cnt == 199)
                ? 12'd128 : rnd_pc());
    chk("tie_done", bus.done, 1);
    chk("tie_to", bus.timeout, 0);
    chk("tie_cnt", bus.cycle_cnt, 200);

    // req back high right after DONE: no restart
    cyc(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0);
      chk("no_rearm", bus.busy, 0);
    end
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("rearm_busy", bus.busy, 1);
    chk("rearm_rst", bus.core_rst, 1);

    // abort on RUN cycle 10
    ndone = 0;
    for (int i = 0; i < 50 && !(m_ph == PH_RUN && m_cnt == 9); i++) begin
      cyc(0, 1, rnd_pc());
      if (bus.done) ndone++;
    end
    cyc(0, 0, rnd_pc());
    if (bus.done) ndone++;
    chk("abort_done", ndone, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_cnt", bus.cycle_cnt, 10);
    cyc(0, 0, 0);

    // reset on RUN cycle 30
    for (int i = 0; i < 60 && !(m_ph == PH_RUN && m_cnt == 29); i++)
      cyc(0, 1, rnd_pc());
    cyc(1, 1, rnd_pc());
    chk("mid_rst_core_rst", bus.core_rst, 1);
    chk("mid_rst_core_en", bus.core_en, 0);
    chk("mid_rst_cnt", bus.cycle_cnt, 0);
    chk("mid_rst_busy", bus.busy, 0);
    cyc(0, 0, 0);

    // random traffic
    q = 1'b0;
    repeat (3000) begin
      r = ($urandom_range(0, 199) == 0);
      if (q) begin
        if ($urandom_range(0, 249) == 0) q = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) q = 1'b1;
      end
      pc = ($urandom_range(0, 79) == 0) ? 12'd128 : rnd_pc();
      cyc(r, q, pc);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
